// File: rtl/proc_selftest_ctrl.sv
// proc_selftest_ctrl: on-chip self-test sequencer for the single-cycle CPU.
// Boots the CPU (resetl/startpc), then walks a checkpoint table: whenever
// currentpc reaches the current entry's PC threshold, MemtoRegOut is compared
// against the entry's expected value. A watchdog bounds the run length.
// Optional macro SELFTEST_CAPTURE_EN: capture MemtoRegOut of the first
// mismatch on fail_actual (otherwise fail_actual is tied to 0).
//
// Handshake: start and cfg_we are single-cycle strobes sampled on the rising
// CLK edge and honoured only while not busy (IDLE or DONE); a cfg_we in the
// same cycle as start is written before the run begins, so the run sees it.
module proc_selftest_ctrl #(
    parameter int NUM_CHECKS   = 2,
    parameter int IDX_W        = 4,
    parameter int RESET_CYCLES = 2,
    parameter int WD_LIMIT     = 255,
    parameter int WD_W         = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [63:0]      cfg_pc,
    input  logic [63:0]      cfg_val,
    input  logic             start,
    input  logic [63:0]      start_pc,
    input  logic [63:0]      currentpc,
    input  logic [63:0]      MemtoRegOut,
    output logic             resetl,
    output logic [63:0]      startpc,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pass_cnt,
    output logic             fail,
    output logic             timeout,
    output logic [IDX_W-1:0] fail_idx,
    output logic [63:0]      fail_actual,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(WD_LIMIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

    state_t           r_state;
    logic             r_resetl;
    logic [63:0]      r_startpc;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_pass_cnt;
    logic             r_fail;
    logic             r_timeout;
    logic [IDX_W-1:0] r_fail_idx;
    logic [IDX_W-1:0] r_idx;
    logic [WD_W-1:0]  r_wd;
    logic [RC_W-1:0]  r_rst_cnt;
    logic [63:0]      r_tbl_pc  [NUM_CHECKS];
    logic [63:0]      r_tbl_val [NUM_CHECKS];
`ifdef SELFTEST_CAPTURE_EN
    logic [63:0]      r_fail_actual;
`endif

    logic             w_cfg_ok;
    logic [63:0]      w_cur_pc;
    logic [63:0]      w_cur_val;
    logic             w_hit;
    logic             w_match;
    logic             w_last;
    logic [WD_W-1:0]  w_wd_next;
    logic             w_wd_exp;

    assign w_cfg_ok  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_hit     = (currentpc >= w_cur_pc);
    assign w_match   = (MemtoRegOut == w_cur_val);
    assign w_last    = (r_idx == IDX_LAST);
    assign w_wd_next = r_wd + 1'b1;
    assign w_wd_exp  = (w_wd_next == WD_LIM);

    // Select the active checkpoint entry; out-of-range indices read as zero.
    always_comb begin
        w_cur_pc  = '0;
        w_cur_val = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_pc  = r_tbl_pc[i];
                w_cur_val = r_tbl_val[i];
            end
        end
    end

    // Checkpoint table writes: only while idle/done, out-of-range index dropped.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (cfg_we && w_cfg_ok && (cfg_idx == IDX_W'(i))) begin
                r_tbl_pc[i]  <= cfg_pc;
                r_tbl_val[i] <= cfg_val;
            end
        end
    end

    // Sequencer FSM: boot reset, checkpoint walk, watchdog, result registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_resetl   <= 1'b1;
            r_startpc  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass_cnt <= '0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_fail_idx <= '0;
            r_idx      <= '0;
            r_wd       <= '0;
            r_rst_cnt  <= '0;
`ifdef SELFTEST_CAPTURE_EN
            r_fail_actual <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RST;
                        r_resetl   <= 1'b0;
                        r_startpc  <= start_pc;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass_cnt <= '0;
                        r_fail     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_fail_idx <= '0;
                        r_idx      <= '0;
                        r_wd       <= '0;
                        r_rst_cnt  <= '0;
`ifdef SELFTEST_CAPTURE_EN
                        r_fail_actual <= '0;
`endif
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == RC_LAST) begin
                        r_resetl <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_wd <= w_wd_next;
                    if (w_hit) begin
                        if (w_match) begin
                            if (r_pass_cnt != 8'hFF) begin
                                r_pass_cnt <= r_pass_cnt + 8'd1;
                            end
                        end else begin
                            r_fail <= 1'b1;
                            if (!r_fail) begin
                                r_fail_idx <= r_idx;
`ifdef SELFTEST_CAPTURE_EN
                                r_fail_actual <= MemtoRegOut;
`endif
                            end
                        end
                        // Index stays on the last entry so it never leaves the table.
                        if (!w_last) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    if (w_wd_exp) begin
                        r_timeout <= 1'b1;
                        r_fail    <= 1'b1;
                    end
                    if ((w_hit && w_last) || w_wd_exp) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resetl    = r_resetl;
    assign startpc   = r_startpc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass_cnt  = r_pass_cnt;
    assign fail      = r_fail;
    assign timeout   = r_timeout;
    assign fail_idx  = r_fail_idx;
    assign dbg_state = r_state;
`ifdef SELFTEST_CAPTURE_EN
    assign fail_actual = r_fail_actual;
`else
    assign fail_actual = '0;
`endif

endmodule

// File: tb/tb_proc_selftest_ctrl.sv
// Directed bench for proc_selftest_ctrl with a simple CPU PC/data model.
module tb_proc_selftest_ctrl;

    localparam int IDX_W = 4;
`ifdef SELFTEST_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [63:0]      cfg_pc = '0;
    logic [63:0]      cfg_val = '0;
    logic             start = 1'b0;
    logic [63:0]      start_pc = '0;
    logic [63:0]      currentpc;
    logic [63:0]      MemtoRegOut;
    logic             resetl;
    logic [63:0]      startpc;
    logic             busy;
    logic             done;
    logic [7:0]       pass_cnt;
    logic             fail;
    logic             timeout;
    logic [IDX_W-1:0] fail_idx;
    logic [63:0]      fail_actual;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    // CPU model: reloads the boot PC while held in reset, then steps by 4.
    logic [63:0] cpu_pc = '0;
    logic        pc_force = 1'b0;
    logic [63:0] pc_force_val = '0;
    logic [63:0] mem_val1 = 64'h1234_5678_9ABC_DEF0;

    proc_selftest_ctrl #(
        .NUM_CHECKS(2), .IDX_W(IDX_W), .RESET_CYCLES(2), .WD_LIMIT(255), .WD_W(16)
    ) dut (
        .CLK(CLK), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_pc(cfg_pc), .cfg_val(cfg_val), .start(start), .start_pc(start_pc),
        .currentpc(currentpc), .MemtoRegOut(MemtoRegOut), .resetl(resetl),
        .startpc(startpc), .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .fail(fail), .timeout(timeout), .fail_idx(fail_idx),
        .fail_actual(fail_actual), .dbg_state(dbg_state)
    );

    // Clock and global time limit.
    always #5 CLK = ~CLK;
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    always @(posedge CLK) begin
        if (!resetl) cpu_pc <= startpc;
        else         cpu_pc <= cpu_pc + 64'd4;
    end
    assign currentpc   = pc_force ? pc_force_val : cpu_pc;
    assign MemtoRegOut = (currentpc == 64'h30) ? 64'hF :
                         (currentpc == 64'h54) ? mem_val1 :
                         (64'h5555_0000_0000_0000 | currentpc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Must be called at a negedge; pulses start, checks the boot reset window.
    task automatic start_run(input logic [63:0] pc);
        start = 1'b1;
        start_pc = pc;
        @(negedge CLK);
        start = 1'b0;
        cfg_we = 1'b0;
        check("startpc_latched", startpc, pc);
        check("rst_resetl_c1", 64'(resetl), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        @(negedge CLK);
        check("rst_resetl_c2", 64'(resetl), 64'd0);
        @(negedge CLK);
        check("run_resetl_high", 64'(resetl), 64'd1);
        check("run_state", 64'(dbg_state), 64'd2);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic write_entry(input logic [IDX_W-1:0] idx, input logic [63:0] pc, input logic [63:0] val);
        cfg_we = 1'b1;
        cfg_idx = idx;
        cfg_pc = pc;
        cfg_val = val;
        @(negedge CLK);
        cfg_we = 1'b0;
    endtask

    task automatic check_pass(input string tag);
        check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'd2);
        check({tag, "_fail"}, 64'(fail), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_resetl", 64'(resetl), 64'd1);
        check("rst_startpc", startpc, 64'd0);
        check("rst_busy0", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_fail_idx", 64'(fail_idx), 64'd0);
        check("rst_fail_actual", fail_actual, 64'd0);

        write_entry(4'd0, 64'h30, 64'hF);
        write_entry(4'd1, 64'h54, 64'h1234_5678_9ABC_DEF0);

        // Passing run
        start_run(64'h0);
        wait_done(100, "pass_done");
        check_pass("pass");
        check("pass_fail_actual", fail_actual, 64'd0);

        // Mismatch on entry 1
        mem_val1 = 64'hDEAD;
        @(negedge CLK);
        start_run(64'h0);
        wait_done(100, "mis_done");
        check("mis_pass_cnt", 64'(pass_cnt), 64'd1);
        check("mis_fail", 64'(fail), 64'd1);
        check("mis_fail_idx", 64'(fail_idx), 64'd1);
        check("mis_timeout", 64'(timeout), 64'd0);
        check("mis_fail_actual", fail_actual, CAP ? 64'hDEAD : 64'd0);
        mem_val1 = 64'h1234_5678_9ABC_DEF0;

        // Skipped thresholds: PC jumps 0x0 -> 0x60 (data mismatches both entries)
        pc_force = 1'b1;
        pc_force_val = 64'h0;
        @(negedge CLK);
        start_run(64'h0);
        @(negedge CLK);
        @(negedge CLK);
        check("jmp_wait_done", 64'(done), 64'd0);
        check("jmp_wait_fail", 64'(fail), 64'd0);
        pc_force_val = 64'h60;
        @(posedge CLK);
        #1;
        check("jmp_c1_done", 64'(done), 64'd0);
        check("jmp_c1_fail", 64'(fail), 64'd1);
        @(posedge CLK);
        #1;
        check("jmp_c2_done", 64'(done), 64'd1);
        check("jmp_pass_cnt", 64'(pass_cnt), 64'd0);
        check("jmp_fail_idx", 64'(fail_idx), 64'd0);
        check("jmp_timeout", 64'(timeout), 64'd0);
        check("jmp_fail_actual", fail_actual, CAP ? 64'h5555_0000_0000_0060 : 64'd0);

        // Watchdog: PC stuck at 0x10, expiry on the 255th RUN cycle
        pc_force_val = 64'h10;
        @(negedge CLK);
        start_run(64'h0);
        for (int i = 0; i < 254; i++) begin
            @(posedge CLK);
        end
        #1;
        check("wd_not_yet", 64'(done), 64'd0);
        @(posedge CLK);
        #1;
        check("wd_done", 64'(done), 64'd1);
        check("wd_timeout", 64'(timeout), 64'd1);
        check("wd_fail", 64'(fail), 64'd1);
        check("wd_pass_cnt", 64'(pass_cnt), 64'd0);
        pc_force = 1'b0;

        // Reset mid-RUN at idx = 1, then clean rerun from 0x8
        @(negedge CLK);
        start_run(64'h0);
        begin
            int n;
            n = 0;
            while (pass_cnt !== 8'd1 && n < 100) begin
                @(negedge CLK);
                n++;
            end
        end
        check("mid_reach_idx1", 64'(pass_cnt), 64'd1);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_state", 64'(dbg_state), 64'd0);
        check("mid_resetl", 64'(resetl), 64'd1);
        check("mid_pass_cnt", 64'(pass_cnt), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        @(negedge CLK);
        reset = 1'b0;
        start_run(64'h8);
        wait_done(100, "rerun_done");
        check_pass("rerun");

        // start and cfg_we while busy are ignored
        @(negedge CLK);
        start_run(64'h0);
        @(negedge CLK);
        start = 1'b1;
        start_pc = 64'h100;
        cfg_we = 1'b1;
        cfg_idx = 4'd0;
        cfg_pc = 64'h0;
        cfg_val = 64'h0;
        @(negedge CLK);
        start = 1'b0;
        cfg_we = 1'b0;
        check("busy_no_restart", 64'(resetl), 64'd1);
        check("busy_startpc", startpc, 64'h0);
        wait_done(100, "busy_done");
        check_pass("busy");

        // Out-of-range write ignored; table still intact
        @(negedge CLK);
        write_entry(4'd2, 64'h0, 64'h0);
        start_run(64'h0);
        wait_done(100, "oor_done");
        check_pass("oor");

        // Write and start in the same cycle from DONE: run uses the new entry
        mem_val1 = 64'hDEAD;
        @(negedge CLK);
        cfg_we = 1'b1;
        cfg_idx = 4'd1;
        cfg_pc = 64'h54;
        cfg_val = 64'hDEAD;
        start_run(64'h0);
        wait_done(100, "same_done");
        check_pass("same");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_selftest_ctrl.md
Name: proc_selftest_ctrl

Overview:
- Synthesizable on-chip self-test sequencer for the single-cycle processor. It drives the processor's boot reset and start PC, then watches `currentpc` against a table of checkpoints.
- At each checkpoint it compares `MemtoRegOut` with an expected value, counts passes, and enforces a watchdog.
- It sits beside `singlecycle` at the top level. It is the hardware counterpart of the simulation checker, driving the CPU boot and consuming the CPU's observation outputs.

Parameters:
- NUM_CHECKS, 2: number of checkpoint table entries (1..16).
- IDX_W, 4: width of checkpoint index; must satisfy 2^IDX_W >= NUM_CHECKS.
- RESET_CYCLES, 2: cycles `resetl` is held low after start (>=1).
- WD_LIMIT, 255: run-cycle budget before timeout.
- WD_W, 16: watchdog counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high block reset.
- cfg_we  in  1  table write strobe; honoured only in IDLE or DONE.
- cfg_idx  in  IDX_W  table entry index; writes with cfg_idx >= NUM_CHECKS are ignored.
- cfg_pc  in  64  checkpoint PC threshold.
- cfg_val  in  64  expected `MemtoRegOut` value at the checkpoint.
- start  in  1  begin a run; sampled in IDLE or DONE.
- start_pc  in  64  boot PC, latched on start.
- currentpc  in  64  from the processor.
- MemtoRegOut  in  64  from the processor.
- resetl  out  1  processor reset, active-low.
- startpc  out  64  processor boot PC.
- busy  out  1  high in RST or RUN.
- done  out  1  high in DONE.
- pass_cnt  out  8  number of checkpoints that matched.
- fail  out  1  sticky; set on any mismatch or timeout.
- timeout  out  1  sticky; watchdog expired.
- fail_idx  out  IDX_W  index of the first mismatching checkpoint.
- fail_actual  out  64  see Optional Feature.

Behaviour:
- Reset values (applied when `reset` is high at a clock edge, in any state, including mid-run):
  - state = IDLE.
  - resetl = 1.
  - startpc = 0.
  - busy = 0, done = 0.
  - pass_cnt = 0, fail = 0, timeout = 0, fail_idx = 0, fail_actual = 0.
  - idx = 0, wd = 0.
  - Table contents are undefined until written; reset does not clear them.
- IDLE:
  - start=1 -> RST.
  - On that edge: latch startpc = start_pc; clear pass_cnt, fail, timeout, fail_idx, fail_actual, idx, wd.
  - resetl goes 0 on the same edge.
- RST:
  - resetl held 0 for exactly RESET_CYCLES cycles, counted by an internal counter.
  - After the last cycle, resetl = 1 and state -> RUN.
  - Checkpoints are not evaluated in RST.
- RUN, each cycle:
  - wd increments.
  - If currentpc >= tbl_pc[idx] (unsigned 64-bit compare), the checkpoint is hit.
  - On a hit, compare MemtoRegOut with tbl_val[idx] in the same cycle:
    - Equal: pass_cnt +1.
    - Not equal: fail = 1; if this is the first failure, fail_idx = idx.
    - Then idx +1.
  - At most one checkpoint is consumed per cycle. Consecutive satisfied thresholds resolve on successive cycles.
  - Hit on idx = NUM_CHECKS-1 -> DONE.
  - wd == WD_LIMIT with no hit that cycle -> timeout = 1, fail = 1, DONE.
  - Hit and watchdog expiry in the same cycle: the hit is evaluated, and timeout is still set.
- DONE:
  - done = 1.
  - Outputs hold.
  - Processor keeps running (resetl = 1).
  - start=1 -> RST, with the same clears as from IDLE.
- start while busy is ignored.
- cfg_we while busy is ignored.
- A cfg_we and start in the same cycle from IDLE or DONE: the write takes effect, and the run uses the new entry.
- pass_cnt saturates at 255.
- All pass ⇔ done & ~fail & (pass_cnt == NUM_CHECKS).

Optional Feature:
- Macro: SELFTEST_CAPTURE_EN.
- Defined:
  - On the first mismatch, fail_actual latches MemtoRegOut.
  - Later mismatches do not overwrite it.
  - Cleared on start and on reset.
- Undefined:
  - fail_actual is constant 0.
  - No capture register is synthesized.
  - All other behaviour is identical.

Test Plan:
- Passing run:
  - Setup: table {(0x30, 0xF), (0x54, 0x123456789ABCDEF0)}; CPU model PC = start_pc + 4/cycle after reset release; MemtoRegOut matches at both PCs; start with start_pc = 0.
  - Required response: resetl low exactly 2 cycles; done; pass_cnt = 2; fail = 0; timeout = 0.
- Mismatch on entry 1:
  - Stimulus: as above, but MemtoRegOut = 0xDEAD at PC 0x54.
  - Required response: done; pass_cnt = 1; fail = 1; fail_idx = 1; fail_actual = 0xDEAD (only with SELFTEST_CAPTURE_EN, else 0).
- Watchdog:
  - Stimulus: PC stuck at 0x10; WD_LIMIT = 255.
  - Required response: DONE after 255 RUN cycles; timeout = 1; fail = 1; pass_cnt = 0.
- Skipped thresholds:
  - Stimulus: PC jumps 0x0 -> 0x60 in one step.
  - Required response: entry 0 evaluated that cycle, entry 1 the next; DONE 2 cycles after the jump.
- Reset mid-RUN:
  - Stimulus: reset asserted at idx = 1.
  - Required response: next edge gives IDLE, resetl = 1, pass_cnt = 0, busy = 0.
  - Then start with start_pc = 0x8: startpc = 0x8 and a clean rerun.
- Ignored inputs while busy:
  - Stimulus: start and cfg_we asserted during RUN.
  - Required response: no restart; table unchanged; results identical to the passing run.
